// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-to-register-file bridge.
package spi_pkg;

  localparam int SPI_RW_BIT      = 7;
  localparam int SPI_ADDR_W      = 6;
  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous pin, plus one history flop
// that turns the synchronized level into single-cycle rise/fall pulses.
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SPI_SYNC_STAGES:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {(SPI_SYNC_STAGES + 1){RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SPI_SYNC_STAGES-1:0], d_i};
    end
  end

  assign level_o = sync_q[SPI_SYNC_STAGES-1];
  assign rise_o  =  sync_q[SPI_SYNC_STAGES-1] & ~sync_q[SPI_SYNC_STAGES];
  assign fall_o  = ~sync_q[SPI_SYNC_STAGES-1] &  sync_q[SPI_SYNC_STAGES];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target turning {rw,0,addr} + data frames into register-file strobes.
// Define SPI_BURST_EN to continue a frame at auto-incremented addresses.
module spi_reg_bridge
  import spi_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              xfer_active
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clock(clock), .reset_n(reset_n), .d_i(sclk),
    .level_o(sclk_level), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // Chip select idles high, so its synchronizer resets high as well.
  spi_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clock(clock), .reset_n(reset_n), .d_i(cs_n),
    .level_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clock(clock), .reset_n(reset_n), .d_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign sync_unused = ^{sclk_level, mosi_rise, mosi_fall};

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_next;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              write_en_q, read_en_q;
  logic              rd_load_q, rd_load_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      rd_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      write_en_q <= wr_pend_q;
      read_en_q  <= rd_pend_q;
      rd_load_q  <= rd_load_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_pend_d  = 1'b0;
    rd_pend_d  = 1'b0;
    rd_load_d  = read_en_q;
    rx_next    = {rx_shift_q[DATA_W-2:0], mosi_s};

    // Register file returns data the cycle after read_en.
    if (rd_load_q) tx_shift_d = rd_data;

`ifdef SPI_BURST_EN
    // Step past a burst write only once its strobe has gone out.
    if (write_en_q) addr_d = addr_q + ADDR_W'(1);
`endif

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = CMD;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end
      end
      CMD, DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            if (state_q == CMD) begin
              addr_d    = rx_next[ADDR_W-1:0];
              rw_d      = rx_next[SPI_RW_BIT];
              rd_pend_d = rx_next[SPI_RW_BIT];
              if (!rx_next[SPI_RW_BIT]) tx_shift_d = '0;
              state_d = DATA;
            end else begin
              if (!rw_q) begin
                wr_data_d = rx_next;
                wr_pend_d = 1'b1;
              end
`ifdef SPI_BURST_EN
              else begin
                addr_d    = addr_q + ADDR_W'(1);
                rd_pend_d = 1'b1;
              end
`else
              state_d = DONE;
`endif
            end
          end
        end else if (sclk_fall && state_q == DATA && bit_cnt_q != '0) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      DONE: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso        = (!cs_s && state_q != DONE) ? tx_shift_q[DATA_W-1] : 1'b0;
  assign address     = addr_q;
  assign wr_data     = wr_data_q;
  assign write_en    = write_en_q;
  assign read_en     = read_en_q;
  assign xfer_active = ~cs_s;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: SPI host model, register-file read
// model and a scoreboard of expected write/read strobes.
module tb_spi_reg_bridge;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       miso;
  logic [5:0] address;
  logic       write_en;
  logic [7:0] wr_data;
  logic       read_en;
  logic       xfer_active;

  always #5 clock = ~clock;

  spi_reg_bridge dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .address(address), .write_en(write_en), .wr_data(wr_data),
    .read_en(read_en), .rd_data(rd_data), .xfer_active(xfer_active)
  );

  typedef struct packed {
    logic       is_write;
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_rise_cyc = 0;
  logic [7:0] host_tx[4];
  logic [7:0] host_rx[4];

  function automatic logic [7:0] reg_model(input logic [5:0] a);
    return {2'b00, a} ^ 8'h30;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Register file read model: data appears the cycle after read_en.
  always @(posedge clock) if (read_en) rd_data <= reg_model(address);

  // Strobe monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && (write_en || read_en)) begin
      check("strobe_overlap", {31'd0, write_en & read_en}, 32'd0);
      if (sb_q.size() == 0) begin
        check("spurious_strobe", {30'd0, write_en, read_en}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind", {31'd0, write_en}, {31'd0, e.is_write});
        check("strobe_addr", {26'd0, address}, {26'd0, e.addr});
        if (e.is_write) check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        check("strobe_latency", cyc - last_rise_cyc, 32'd4);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
    sb_q.push_back('{is_write: 1'b1, addr: a, data: d});
  endtask

  task automatic push_rd(input logic [5:0] a);
    sb_q.push_back('{is_write: 1'b0, addr: a, data: 8'h00});
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    host_tx[0] = b0;
    host_tx[1] = b1;
    host_tx[2] = b2;
    host_tx[3] = 8'h00;
    for (int i = 0; i < 4; i++) host_rx[i] = 8'h00;
  endtask

  // Mode-0 host at SCLK = clock/16: change MOSI on fall, sample MISO at rise.
  task automatic spi_frame(input int nbits, input bit hold_cs);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = host_tx[i / 8][7 - (i % 8)];
      wait_clk(8);
      host_rx[i / 8][7 - (i % 8)] = miso;
      sclk = 1'b1;
      last_rise_cyc = cyc;
      if (i == 0) check("xfer_active_in_frame", {31'd0, xfer_active}, 32'd1);
      wait_clk(8);
      sclk = 1'b0;
    end
    if (!hold_cs) begin
      wait_clk(8);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(24);
      check("xfer_active_idle", {31'd0, xfer_active}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_address"}, {26'd0, address}, 32'd0);
    check({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    check({tag, "_write_en"}, {31'd0, write_en}, 32'd0);
    check({tag, "_read_en"}, {31'd0, read_en}, 32'd0);
    check({tag, "_miso"}, {31'd0, miso}, 32'd0);
    check({tag, "_xfer_active"}, {31'd0, xfer_active}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    wait_clk(4);
    check_all_zero("reset");
    reset_n = 1'b1;
    wait_clk(8);

    // Single write
    set_tx(8'h04, 8'hA5, 8'h00);
    push_wr(6'h04, 8'hA5);
    spi_frame(16, 1'b0);
    check("write_miso_zero", {24'd0, host_rx[1]}, 32'd0);
    check("sb_drain_write", sb_q.size(), 32'd0);

    // Single read
    set_tx(8'h8C, 8'h00, 8'h00);
    push_rd(6'h0C);
`ifdef SPI_BURST_EN
    push_rd(6'h0D);
`endif
    spi_frame(16, 1'b0);
    check("read_miso", {24'd0, host_rx[1]}, {24'd0, reg_model(6'h0C)});
    check("sb_drain_read", sb_q.size(), 32'd0);

    // Aborted data byte, then a clean write
    set_tx(8'h20, 8'h5A, 8'h00);
    spi_frame(13, 1'b0);
    check("sb_drain_abort", sb_q.size(), 32'd0);
    set_tx(8'h21, 8'h7F, 8'h00);
    push_wr(6'h21, 8'h7F);
    spi_frame(16, 1'b0);
    check("sb_drain_after_abort", sb_q.size(), 32'd0);

    // Three-byte write frame
    set_tx(8'h06, 8'h11, 8'h22);
    push_wr(6'h06, 8'h11);
`ifdef SPI_BURST_EN
    push_wr(6'h07, 8'h22);
`endif
    spi_frame(24, 1'b0);
`ifndef SPI_BURST_EN
    check("done_miso_zero", {24'd0, host_rx[2]}, 32'd0);
`endif
    check("sb_drain_3byte", sb_q.size(), 32'd0);

`ifdef SPI_BURST_EN
    // Read burst wrapping 0x3F -> 0x00 (plus the prefetch after byte 2)
    set_tx(8'hBF, 8'h00, 8'h00);
    push_rd(6'h3F);
    push_rd(6'h00);
    push_rd(6'h01);
    spi_frame(24, 1'b0);
    check("burst_rd_byte0", {24'd0, host_rx[1]}, {24'd0, reg_model(6'h3F)});
    check("burst_rd_byte1", {24'd0, host_rx[2]}, {24'd0, reg_model(6'h00)});
    check("sb_drain_burst", sb_q.size(), 32'd0);
`endif

    // Reset in the middle of a read data byte
    set_tx(8'h8C, 8'h00, 8'h00);
    push_rd(6'h0C);
    spi_frame(11, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(8);
    check("sb_drain_midreset", sb_q.size(), 32'd0);
    set_tx(8'h31, 8'h15, 8'h00);
    push_wr(6'h31, 8'h15);
    spi_frame(16, 1'b0);
    check("sb_drain_post_reset", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
